// File: rtl/shared_adder_arbiter_pkg.sv
// Shared types and helpers for the shared adder arbiter.
//   sa_state_t : state of the single-entry result register (IDLE = empty, FULL = holding a result)
//   id_width() : width of a requester index for R requesters (at least 1 bit)
package shared_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } sa_state_t;

  function automatic int id_width(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/shared_adder_arbiter_if.sv
// Request/response bundle between the operand sources, the consumer and the shared adder.
//   master modport : operand sources + consumer (drive req_valid/req_a/req_b/rsp_ready)
//   slave modport  : shared_adder_arbiter (drives req_ready and the rsp_* result)
// Signals:
//   req_valid [R]     requester i has an operand pair
//   req_a/req_b [R][N] operand pairs, one per requester
//   req_ready [R]     one-hot grant
//   rsp_valid         result register holds a result
//   rsp_ready         consumer accepts the result
//   rsp_id [IDW]      requester index of the held result
//   rsp_sum [N]       sum (wrapped or saturated, see top)
//   rsp_carry         unsigned overflow of a+b
interface shared_adder_arbiter_if #(
  parameter int N = 32,
  parameter int R = 4
);
  import shared_adder_pkg::*;

  localparam int IDW = id_width(R);

  logic [R-1:0]        req_valid;
  logic [R-1:0][N-1:0] req_a;
  logic [R-1:0][N-1:0] req_b;
  logic [R-1:0]        req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [N-1:0]        rsp_sum;
  logic                rsp_carry;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request scanning upward from ptr_i, wrapping
// modulo R. Purely combinational.
//   req_i    [R]   request vector
//   en_i           grant enable; no grant when low
//   ptr_i    [IDW] highest-priority index this cycle
//   gnt_o    [R]   one-hot grant (all zero when nothing granted)
//   gnt_id_o [IDW] index of the granted request (0 when nothing granted)
module rr_arbiter
  import shared_adder_pkg::*;
#(
  parameter int R   = 4,
  parameter int IDW = id_width(R)
) (
  input  logic [R-1:0]   req_i,
  input  logic           en_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [R-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o
);

  // Concatenating the request vector with itself turns the modular scan into a linear one:
  // positions ptr..ptr+R-1 of the doubled vector cover every requester exactly once.
  logic [2*R-1:0] req_dbl;
  logic           found;

  always_comb begin
    req_dbl  = {req_i, req_i};
    found    = 1'b0;
    gnt_id_o = '0;
    for (int i = 0; i < R; i++) begin
      int idx;
      idx = int'(ptr_i) + i;
      if (!found && en_i && req_dbl[idx]) begin
        found    = 1'b1;
        gnt_id_o = (idx >= R) ? IDW'(idx - R) : IDW'(idx);
      end
    end
    gnt_o = found ? (R'(1) << gnt_id_o) : '0;
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Shares one N-bit adder among R requesters with work-conserving round-robin arbitration.
// The granted operand pair is added and captured in a single-entry result register tagged with
// the requester index; results appear the cycle after the operands are accepted.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   sa   shared_adder_arbiter_if.slave (request handshake in, result handshake out)
// Build option:
//   SHARED_ADDER_SAT_EN  defined: saturate rsp_sum to all ones on carry; undefined: modular wrap.
//   rsp_carry reports the overflow in both builds.
//
// state | meaning
// IDLE  | result register empty
// FULL  | result register holds a result for the consumer
module shared_adder_arbiter
  import shared_adder_pkg::*;
#(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_adder_arbiter_if.slave sa
);

  localparam int IDW = id_width(R);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_FULL = FULL;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           can_accept;
  logic           accept;
  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_id;

  logic [N-1:0]   op_a, op_b;
  logic [N:0]     raw_sum;
  logic [N-1:0]   sum_d;

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [N-1:0]   rsp_sum_q;
  logic           rsp_carry_q;

  // The register can take a new result when empty or when the held one leaves this cycle.
  // Grants are suppressed during reset so pending requests are not consumed.
  assign can_accept = (state_q == ST_IDLE) | sa.rsp_ready;

  rr_arbiter #(
    .R   (R),
    .IDW (IDW)
  ) u_arb (
    .req_i    (sa.req_valid),
    .en_i     (can_accept & ~rst),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign sa.req_ready = gnt;
  assign accept       = |(sa.req_valid & gnt);

  assign op_a    = sa.req_a[gnt_id];
  assign op_b    = sa.req_b[gnt_id];
  assign raw_sum = {1'b0, op_a} + {1'b0, op_b};

`ifdef SHARED_ADDER_SAT_EN
  assign sum_d = raw_sum[N] ? {N{1'b1}} : raw_sum[N-1:0];
`else
  assign sum_d = raw_sum[N-1:0];
`endif

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == IDW'(R - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_FULL;
      ST_FULL: if (sa.rsp_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= (state_d == ST_FULL);
      if (accept) begin
        rsp_id_q    <= gnt_id;
        rsp_sum_q   <= sum_d;
        rsp_carry_q <= raw_sum[N];
      end
    end
  end

  assign sa.rsp_valid = rsp_valid_q;
  assign sa.rsp_id    = rsp_id_q;
  assign sa.rsp_sum   = rsp_sum_q;
  assign sa.rsp_carry = rsp_carry_q;

endmodule
